// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states and port-owner decode.
package dmem_arb_pkg;

   typedef enum logic {
      S_NORMAL = 1'b0,
      S_FORCE  = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_EXT  = 2'd2
   } owner_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the CPU load/store path and one external
// requester. CPU wins by default; a starvation counter forces one external grant.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req_rd,
   input  logic              cpu_req_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ext_gnt,
   output logic              ext_rvalid,
   output logic [DATA_W-1:0] ext_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   if (STARVE_LIMIT < 1) begin : g_bad_limit
      $error("dmem_arbiter: STARVE_LIMIT must be >= 1");
   end

   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

   arb_state_t       state;
   owner_t           owner;
   logic [CNT_W-1:0] starve_cnt;
   logic             cpu_req;
   logic             ext_rd_gnt;

   // rd+wr together is a store: mem_we follows cpu_req_wr alone
   assign cpu_req    = cpu_req_rd | cpu_req_wr;
   assign ext_rd_gnt = ext_gnt & ~ext_we;

   always_comb begin
      owner     = OWN_NONE;
      cpu_stall = 1'b0;
      ext_gnt   = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      cpu_rdata = '0;
      if (rst) begin
         if (ext_req && (state == S_FORCE || !cpu_req))
            owner = OWN_EXT;
         else if (cpu_req)
            owner = OWN_CPU;
         // ext only owns over a live CPU request during the forced cycle
         cpu_stall = (owner == OWN_EXT) && cpu_req;
         ext_gnt   = (owner == OWN_EXT);
         case (owner)
            OWN_CPU: begin
               mem_addr  = cpu_addr;
               mem_wdata = cpu_wdata;
               mem_we    = cpu_req_wr;
               cpu_rdata = mem_rdata;
            end
            OWN_EXT: begin
               mem_addr  = ext_addr;
               mem_wdata = ext_wdata;
               mem_we    = ext_we;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_NORMAL;
         starve_cnt <= '0;
         ext_rvalid <= 1'b0;
         ext_rdata  <= '0;
      end else begin
         ext_rvalid <= ext_rd_gnt;
         if (ext_rd_gnt)
            ext_rdata <= mem_rdata;
         if (state == S_FORCE) begin
            state      <= S_NORMAL;
            starve_cnt <= '0;
         end else if (owner == OWN_EXT) begin
            starve_cnt <= '0;
         end else if (ext_req) begin
            if (starve_cnt != CNT_MAX)
               starve_cnt <= starve_cnt + 1'b1;
            if (starve_cnt == CNT_LAST)
               state <= S_FORCE;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized + directed bench for dmem_arbiter against a behavioural ownership/starvation model.
module tb_dmem_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LIM = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cpu_req_rd = 1'b0, cpu_req_wr = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_stall;
   logic          ext_req = 1'b0, ext_we = 1'b0;
   logic [AW-1:0] ext_addr = '0;
   logic [DW-1:0] ext_wdata = '0;
   logic          ext_gnt, ext_rvalid;
   logic [DW-1:0] ext_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic [DW-1:0] mem_rdata;

   int vectors = 0;
   int miscompares = 0;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst),
      .cpu_req_rd(cpu_req_rd), .cpu_req_wr(cpu_req_wr), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_word(input int i);
      logic [7:0] b;
      b = i[7:0];
      if (i == 'h40) return 32'hDEADBEEF;
      return {b, ~b, b ^ 8'h5A, 8'hC3};
   endfunction

   // data memory attached to the arbiter's memory port
   logic [DW-1:0] mem [256];
   assign mem_rdata = mem[mem_addr[7:0]];
   initial begin : env_mem
      for (int i = 0; i < 256; i++) mem[i] = init_word(i);
      forever begin
         @(posedge clk);
         if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      end
   end

   // reference model: who gets the port, expected memory image, starvation tally
   typedef struct packed {
      logic          gnt;
      logic          stall;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] crd;
   } exp_t;

   logic [DW-1:0] exp_mem [256];
   int            den = 0;
   bit            forced = 1'b0;
   logic          exp_rv = 1'b0;
   logic [DW-1:0] exp_rd = '0;

   function automatic exp_t model_out();
      exp_t e;
      bit creq, ewin, cwin;
      e = '0;
      if (rst) begin
         creq = cpu_req_rd | cpu_req_wr;
         ewin = ext_req && (forced || !creq);
         cwin = creq && !ewin;
         e.gnt   = ewin;
         e.stall = ewin && creq;
         if (cwin) begin
            e.we = cpu_req_wr; e.addr = cpu_addr; e.wdata = cpu_wdata;
            e.crd = exp_mem[cpu_addr[7:0]];
         end else if (ewin) begin
            e.we = ext_we; e.addr = ext_addr; e.wdata = ext_wdata;
         end
      end
      return e;
   endfunction

   initial begin : model
      exp_t e;
      for (int i = 0; i < 256; i++) exp_mem[i] = init_word(i);
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            den <= 0; forced <= 1'b0; exp_rv <= 1'b0; exp_rd <= '0;
         end else begin
            e = model_out();
            if (e.we) exp_mem[e.addr[7:0]] <= e.wdata;
            exp_rv <= e.gnt && !ext_we;
            if (e.gnt && !ext_we) exp_rd <= exp_mem[ext_addr[7:0]];
            if (forced) begin
               forced <= 1'b0; den <= 0;
            end else if (e.gnt) begin
               den <= 0;
            end else if (ext_req) begin
               den <= den + 1;
               forced <= (den + 1 >= LIM);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin : compare
      exp_t e;
      e = model_out();
      chk("ext_gnt",    {31'b0, ext_gnt},    {31'b0, e.gnt});
      chk("cpu_stall",  {31'b0, cpu_stall},  {31'b0, e.stall});
      chk("mem_we",     {31'b0, mem_we},     {31'b0, e.we});
      chk("mem_addr",   mem_addr,            e.addr);
      chk("mem_wdata",  mem_wdata,           e.wdata);
      chk("cpu_rdata",  cpu_rdata,           e.crd);
      chk("ext_rvalid", {31'b0, ext_rvalid}, {31'b0, exp_rv});
      chk("ext_rdata",  ext_rdata,           exp_rd);
   end

   task automatic drive(input bit rd, input bit wr, input logic [AW-1:0] ca, input logic [DW-1:0] cw,
                        input bit er, input bit ew, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
      cpu_req_rd = rd; cpu_req_wr = wr; cpu_addr = ca; cpu_wdata = cw;
      ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      drive(0, 0, '0, '0, 0, 0, '0, '0);
   endtask

   // n cycles of CPU loads with an external read held, each must be denied
   task automatic deny_run(input int n, input string tag);
      for (int c = 0; c < n; c++) begin
         drive(1, 0, 32'h20 + c, '0, 1, 0, 32'h41, '0);
         #5 chk(tag, {31'b0, ext_gnt}, 32'd0);
         tick();
      end
   endtask

   initial begin : stim
      bit            pend;
      logic          p_we;
      logic [AW-1:0] p_addr;
      logic [DW-1:0] p_wd;
      int            r;

      idle();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rvalid", {31'b0, ext_rvalid}, 32'd0);
      chk("rst_rdata",  ext_rdata, 32'd0);
      chk("rst_gnt",    {31'b0, ext_gnt}, 32'd0);
      rst = 1'b1;
      tick();

      // idle external read
      drive(0, 0, '0, '0, 1, 0, 32'h40, '0);
      #5 chk("idle_rd_gnt", {31'b0, ext_gnt}, 32'd1);
      tick();
      idle();
      #5 chk("idle_rd_rvalid", {31'b0, ext_rvalid}, 32'd1);
      chk("idle_rd_data", ext_rdata, 32'hDEADBEEF);
      tick();
      #5 chk("rvalid_pulse", {31'b0, ext_rvalid}, 32'd0);
      chk("rdata_hold", ext_rdata, 32'hDEADBEEF);
      tick();

      // starvation: 8 denials, forced grant stalls the CPU, then CPU owns again
      deny_run(LIM, "starve_deny");
      drive(1, 0, 32'h28, '0, 1, 0, 32'h41, '0);
      #5 chk("force_gnt", {31'b0, ext_gnt}, 32'd1);
      chk("force_stall", {31'b0, cpu_stall}, 32'd1);
      chk("force_cpu_rdata", cpu_rdata, 32'd0);
      tick();
      drive(1, 0, 32'h30, '0, 0, 0, '0, '0);
      #5 chk("post_force_gnt", {31'b0, ext_gnt}, 32'd0);
      chk("post_force_stall", {31'b0, cpu_stall}, 32'd0);
      chk("post_force_rdata", ext_rdata, init_word('h41));
      chk("post_force_cpu_rdata", cpu_rdata, init_word('h30));
      tick();

      // write collision on 0x10: CPU first, external next
      drive(0, 1, 32'h10, 32'h11, 1, 1, 32'h10, 32'h22);
      #5 chk("coll_gnt", {31'b0, ext_gnt}, 32'd0);
      chk("coll_wdata", mem_wdata, 32'h11);
      tick();
      drive(0, 0, '0, '0, 1, 1, 32'h10, 32'h22);
      #5 chk("coll_cpu_wins", mem[8'h10], 32'h11);
      chk("coll_ext_gnt", {31'b0, ext_gnt}, 32'd1);
      tick();
      idle();
      #5 chk("coll_ext_wr", mem[8'h10], 32'h22);
      tick();

      // forced cycle abandoned by the external requester
      deny_run(LIM, "abandon_deny");
      drive(1, 0, 32'h40, '0, 0, 0, '0, '0);
      #5 chk("abandon_gnt", {31'b0, ext_gnt}, 32'd0);
      chk("abandon_stall", {31'b0, cpu_stall}, 32'd0);
      chk("abandon_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
      tick();
      drive(1, 0, 32'h40, '0, 1, 0, 32'h41, '0);
      #5 chk("abandon_normal", {31'b0, ext_gnt}, 32'd0);
      tick();
      drive(0, 0, '0, '0, 1, 0, 32'h41, '0);
      tick();
      idle();
      tick();

      // reset while an external read is being granted
      drive(0, 0, '0, '0, 1, 0, 32'h40, '0);
      #2 rst = 1'b0;
      #3 chk("rst_mid_gnt", {31'b0, ext_gnt}, 32'd0);
      chk("rst_mid_addr", mem_addr, 32'd0);
      tick();
      chk("rst_mid_rvalid", {31'b0, ext_rvalid}, 32'd0);
      chk("rst_mid_rdata", ext_rdata, 32'd0);
      rst = 1'b1;
      idle();
      tick();

      // reset during the forced cycle: no write, and the tally restarts
      deny_run(LIM, "rstf_deny");
      drive(1, 1, 32'h50, 32'hAA, 1, 0, 32'h41, '0);
      #2 rst = 1'b0;
      #3 chk("rstf_we", {31'b0, mem_we}, 32'd0);
      chk("rstf_stall", {31'b0, cpu_stall}, 32'd0);
      chk("rstf_cpu_rdata", cpu_rdata, 32'd0);
      tick();
      rst = 1'b1;
      deny_run(LIM, "rstf_redeny");
      drive(1, 0, 32'h28, '0, 1, 0, 32'h41, '0);
      #5 chk("rstf_force_gnt", {31'b0, ext_gnt}, 32'd1);
      chk("rstf_mem50", mem[8'h50], init_word('h50));
      tick();
      idle();
      tick();

      // random traffic; external requester holds its request until granted
      pend = 1'b0; p_we = 1'b0; p_addr = '0; p_wd = '0;
      for (int n = 0; n < 3000; n++) begin
         if (!pend && $urandom_range(0, 2) == 0) begin
            pend = 1'b1;
            p_we = 1'($urandom_range(0, 1));
            p_addr = AW'($urandom_range(0, 255));
            p_wd = $urandom;
         end
         r = $urandom_range(0, 5);
         drive(r == 1 || r == 2 || r == 5, r == 3 || r == 4 || r == 5,
               AW'($urandom_range(0, 255)), $urandom, pend, p_we, p_addr, p_wd);
         if ($urandom_range(0, 299) == 0) begin
            #2 rst = 1'b0;
            pend = 1'b0;
            #3;
         end else begin
            #5;
            if (ext_gnt) pend = 1'b0;
         end
         tick();
         rst = 1'b1;
      end
      idle();
      tick();

      for (int i = 0; i < 256; i++) chk("mem_final", mem[i], exp_mem[i]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
